// File: rtl/zone_mean_fifo.sv
// Zone-mean buffer: strips row padding, tags row/frame markers and queues
// entries in a first-word-fall-through FIFO drained over valid/ready.
module zone_mean_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ZONE_COLS  = 40,
    parameter int unsigned ROW_STRIDE = 42,
    parameter int unsigned ZONE_ROWS  = 24,
    parameter int unsigned AW         = 6,
    parameter int unsigned GAP_RST    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sol,
    output logic              out_eof,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic              frame_done
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned COL_W = (ROW_STRIDE > 1) ? $clog2(ROW_STRIDE) : 1;
    localparam int unsigned ROW_W = (ZONE_ROWS > 1) ? $clog2(ZONE_ROWS) : 1;
    localparam int unsigned ENT_W = DATA_W + 2;

    logic [COL_W-1:0] col, col_eff;
    logic [ROW_W-1:0] row, row_eff;
    logic             active, last_col, slot_sol, slot_eof;
    logic             full, push, pop, drop, load;
    logic [AW:0]      mem_cnt;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [ENT_W-1:0] mem [DEPTH];

    // Slot classification; an sof slot is forced to column 0 of row 0.
    always_comb begin
        col_eff  = in_sof ? '0 : col;
        row_eff  = in_sof ? '0 : row;
        active   = in_valid && (32'(col_eff) < ZONE_COLS);
        last_col = (32'(col_eff) == ZONE_COLS - 1);
        slot_sol = (col_eff == '0);
        slot_eof = last_col && (32'(row_eff) == ZONE_ROWS - 1);
        full     = (level == (AW+1)'(DEPTH));
        pop      = out_valid && out_ready;
        push     = active && (!full || pop);
        drop     = active && full && !pop;
        // Entries still in the array, i.e. not yet in the output register.
        mem_cnt  = level - (AW+1)'(out_valid);
        load     = (mem_cnt != '0) && (!out_valid || pop);
    end

    // Column/row position tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            col <= (32'(col_eff) == ROW_STRIDE - 1) ? '0 : col_eff + 1'b1;
            if (last_col)
                row <= (32'(row_eff) == ZONE_ROWS - 1) ? '0 : row_eff + 1'b1;
            else
                row <= row_eff;
        end else if (GAP_RST != 0) begin
            col <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {slot_eof, slot_sol, in_data};
    end

    // Pointers, fill level, output register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sol    <= 1'b0;
            out_eof    <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (load)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (load) begin
                out_valid                     <= 1'b1;
                {out_eof, out_sol, out_data}  <= mem[rd_ptr];
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            if (in_valid && in_sof)
                overflow <= drop;
            else if (drop)
                overflow <= 1'b1;
            frame_done <= pop && out_eof;
        end
    end

endmodule
